// File: rtl/cam_controller_if.sv
// Request, result and CAM-array signals of cam_controller, bundled for port hookup.
// slave = the controller itself; master = the request source / array side that drives it.
interface cam_controller_if #(
  parameter int CAM_WIDTH  = 8,
  parameter int CAM_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  wr_inv;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [CAM_WIDTH-1:0]  wr_word;
  logic                  srch_valid;
  logic                  srch_ready;
  logic [CAM_WIDTH-1:0]  srch_word;
  logic [CAM_WIDTH-1:0]  srch_mask;
  logic                  res_valid;
  logic                  res_ready;
  logic                  res_hit;
  logic [ADDR_WIDTH-1:0] res_addr;
  logic                  res_last;
  logic [CAM_DEPTH-1:0]  we_decoded_row_address;
  logic [CAM_WIDTH-1:0]  search_word;
  logic [CAM_WIDTH-1:0]  dont_care_mask;
  logic [CAM_DEPTH-1:0]  decoded_match_address;

  modport slave (
    input  wr_valid, wr_inv, wr_addr, wr_word, srch_valid, srch_word, srch_mask,
           res_ready, decoded_match_address,
    output wr_ready, srch_ready, res_valid, res_hit, res_addr, res_last,
           we_decoded_row_address, search_word, dont_care_mask
  );

  modport master (
    output wr_valid, wr_inv, wr_addr, wr_word, srch_valid, srch_word, srch_mask,
           res_ready, decoded_match_address,
    input  wr_ready, srch_ready, res_valid, res_hit, res_addr, res_last,
           we_decoded_row_address, search_word, dont_care_mask
  );
endinterface

// File: rtl/cam_controller.sv
// CAM sequencer: 1-cycle array write, 1-cycle search sample, then matches streamed lowest row first.
// Write busy 2 cycles; first result 2 cycles after search accept; results hold while res_ready is low.
module cam_controller #(
  parameter int CAM_WIDTH  = 8,
  parameter int CAM_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input logic             clk,
  input logic             rst,
  cam_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, SEARCH, REPORT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CAM_WIDTH-1:0]  word_q, word_d;
  logic [CAM_WIDTH-1:0]  mask_q, mask_d;
  logic                  inv_q, inv_d;
  logic [CAM_DEPTH-1:0]  valid_q, valid_d;
  logic [CAM_DEPTH-1:0]  pend_q, pend_d;

  logic [ADDR_WIDTH-1:0] low_idx;
  logic [CAM_DEPTH-1:0]  pend_rest;
  logic                  addr_in_range;

  always_comb begin
    low_idx = '0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (pend_q[i]) low_idx = ADDR_WIDTH'(i);
    end
  end

  // Clearing the lowest set bit; zero afterwards means exactly one match was left.
  assign pend_rest     = pend_q & (pend_q - CAM_DEPTH'(1));
  assign addr_in_range = int'(addr_q) < CAM_DEPTH;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    mask_d  = mask_q;
    inv_d   = inv_q;
    valid_d = valid_q;
    pend_d  = pend_q;

    bus.wr_ready               = 1'b0;
    bus.srch_ready             = 1'b0;
    bus.res_valid              = 1'b0;
    bus.res_hit                = 1'b0;
    bus.res_addr               = '0;
    bus.res_last               = 1'b0;
    bus.we_decoded_row_address = '0;
    bus.search_word            = '0;
    bus.dont_care_mask         = '0;

    unique case (state_q)
      IDLE: begin
        bus.wr_ready   = !rst;
        bus.srch_ready = !rst && !bus.wr_valid;
        if (bus.wr_valid && bus.wr_ready) begin
          addr_d  = bus.wr_addr;
          word_d  = bus.wr_word;
          inv_d   = bus.wr_inv;
          state_d = WRITE;
        end else if (bus.srch_valid && bus.srch_ready) begin
          word_d  = bus.srch_word;
          mask_d  = bus.srch_mask;
          state_d = SEARCH;
        end
      end
      WRITE: begin
        bus.search_word = word_q;
        if (addr_in_range) begin
          if (!inv_q) bus.we_decoded_row_address = CAM_DEPTH'(1) << addr_q;
          valid_d[addr_q] = !inv_q;
        end
        state_d = IDLE;
      end
      SEARCH: begin
        bus.search_word    = word_q;
        bus.dont_care_mask = mask_q;
        pend_d             = bus.decoded_match_address & valid_q;
        state_d            = REPORT;
      end
      REPORT: begin
        bus.res_valid = 1'b1;
        if (pend_q != '0) begin
          bus.res_hit  = 1'b1;
          bus.res_addr = low_idx;
          bus.res_last = (pend_rest == '0);
          if (bus.res_ready) begin
            pend_d = pend_rest;
            if (bus.res_last) state_d = IDLE;
          end
        end else begin
          bus.res_last = 1'b1;
          if (bus.res_ready) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      mask_q  <= '0;
      inv_q   <= 1'b0;
      valid_q <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      inv_q   <= inv_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_cam_controller.sv
// Bench for cam_controller: behavioural CAM array, directed table, corner sequences, random ops vs model.
module tb_cam_controller;
  localparam int W = 8;
  localparam int D = 8;
  localparam int A = 3;

  typedef struct {
    int         op;     // 0 write, 1 invalidate, 2 search
    logic [2:0] addr;
    logic [7:0] word;
    logic [7:0] mask;
    logic [7:0] exp;    // expected we for write/inv, expected hit rows for search
    int         stall;
  } vec_t;

  typedef struct {
    logic       hit;
    logic [2:0] addr;
    logic       last;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [W-1:0] arr [D];
  logic [W-1:0] m_data [D];
  bit           m_vld  [D];

  always #5 clk = ~clk;

  cam_controller_if #(.CAM_WIDTH(W), .CAM_DEPTH(D), .ADDR_WIDTH(A)) bus ();
  cam_controller #(.CAM_WIDTH(W), .CAM_DEPTH(D), .ADDR_WIDTH(A)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural CAM array: rows written through the one-hot enables, match is combinational.
  always @(posedge clk) begin
    for (int r = 0; r < D; r++)
      if (bus.we_decoded_row_address[r]) arr[r] <= bus.search_word;
  end

  always_comb begin
    logic [D-1:0] m;
    m = '0;
    for (int r = 0; r < D; r++)
      m[r] = (((arr[r] ^ bus.search_word) & ~bus.dont_care_mask) == '0);
    bus.decoded_match_address = m;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_hits(input logic [7:0] key, input logic [7:0] mask);
    logic [7:0] h;
    h = '0;
    for (int r = 0; r < D; r++)
      if (m_vld[r] && (((m_data[r] ^ key) & ~mask) == 8'h00)) h[r] = 1'b1;
    return h;
  endfunction

  task automatic do_write(input logic [2:0] addr, input logic [7:0] word, input logic inv,
                          input logic [7:0] exp_we);
    @(negedge clk);
    chk("wr_ready_idle", bus.wr_ready, 1);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr;
    bus.wr_word  = word;
    bus.wr_inv   = inv;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    chk("wr_we_onehot", bus.we_decoded_row_address, exp_we);
    chk("wr_search_word", bus.search_word, word);
    chk("wr_mask_zero", bus.dont_care_mask, 0);
    chk("wr_ready_busy", bus.wr_ready, 0);
    m_vld[addr] = !inv;
    if (!inv) m_data[addr] = word;
  endtask

  task automatic do_search(input logic [7:0] key, input logic [7:0] mask, input logic [7:0] hits,
                           input int stall, input bit rand_rdy);
    res_t q[$];
    res_t e;
    int   cyc;
    int   stall_left;
    bit   first;
    bit   stalled;
    logic rdy;
    logic p_hit;
    logic p_last;
    logic [2:0] p_addr;
    @(negedge clk);
    chk("srch_ready_idle", bus.srch_ready, 1);
    bus.srch_valid = 1'b1;
    bus.srch_word  = key;
    bus.srch_mask  = mask;
    bus.res_ready  = 1'b0;
    @(negedge clk);
    bus.srch_valid = 1'b0;
    chk("srch_key_out", bus.search_word, key);
    chk("srch_mask_out", bus.dont_care_mask, mask);
    chk("srch_we_zero", bus.we_decoded_row_address, 0);
    chk("srch_res_early", bus.res_valid, 0);
    if (hits == 8'h00) begin
      e.hit = 1'b0; e.addr = 3'd0; e.last = 1'b1;
      q.push_back(e);
    end else begin
      for (int r = 0; r < D; r++) begin
        if (hits[r]) begin
          e.hit = 1'b1; e.addr = 3'(r); e.last = ((hits >> (r + 1)) == 8'h00);
          q.push_back(e);
        end
      end
    end
    cyc = 0; first = 1'b1; stalled = 1'b0; stall_left = stall;
    p_hit = 1'b0; p_addr = '0; p_last = 1'b0;
    while (q.size() > 0 && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (first) begin
        chk("first_res_latency", bus.res_valid, 1);
        first = 1'b0;
      end
      if (stalled) begin
        chk("stall_hold_valid", bus.res_valid, 1);
        chk("stall_hold_hit", bus.res_hit, p_hit);
        chk("stall_hold_addr", bus.res_addr, p_addr);
        chk("stall_hold_last", bus.res_last, p_last);
      end
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      bus.res_ready = rdy;
      if (bus.res_valid) begin
        if (rdy) begin
          e = q.pop_front();
          chk("res_hit", bus.res_hit, e.hit);
          chk("res_addr", bus.res_addr, e.addr);
          chk("res_last", bus.res_last, e.last);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          p_hit = bus.res_hit; p_addr = bus.res_addr; p_last = bus.res_last;
        end
      end
    end
    if (q.size() > 0) chk("result_timeout", q.size(), 0);
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("post_res_valid", bus.res_valid, 0);
    chk("post_srch_ready", bus.srch_ready, 1);
  endtask

  vec_t tbl[9];

  initial begin
    logic [7:0] pool [4];
    logic [7:0] key;
    logic [7:0] mask;
    logic [2:0] addr;
    int         op;

    rst = 1'b1;
    bus.wr_valid = 0; bus.wr_inv = 0; bus.wr_addr = '0; bus.wr_word = '0;
    bus.srch_valid = 0; bus.srch_word = '0; bus.srch_mask = '0; bus.res_ready = 0;
    for (int r = 0; r < D; r++) begin m_vld[r] = 0; m_data[r] = '0; end

    tbl[0] = '{2, 3'd0, 8'h00, 8'h00, 8'h00, 0};
    tbl[1] = '{0, 3'd2, 8'hA5, 8'h00, 8'h04, 0};
    tbl[2] = '{0, 3'd6, 8'hA5, 8'h00, 8'h40, 0};
    tbl[3] = '{2, 3'd0, 8'hA5, 8'h00, 8'h44, 0};
    tbl[4] = '{0, 3'd1, 8'h3C, 8'h00, 8'h02, 0};
    tbl[5] = '{2, 3'd0, 8'h30, 8'h0F, 8'h02, 0};
    tbl[6] = '{2, 3'd0, 8'h30, 8'h00, 8'h00, 0};
    tbl[7] = '{1, 3'd2, 8'h00, 8'h00, 8'h00, 0};
    tbl[8] = '{2, 3'd0, 8'hA5, 8'h00, 8'h40, 3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.wr_valid = 1'b1;
    #1;
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_srch_ready", bus.srch_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_we", bus.we_decoded_row_address, 0);
    chk("rst_search_word", bus.search_word, 0);
    bus.wr_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rel_wr_ready", bus.wr_ready, 1);
    chk("rel_srch_ready", bus.srch_ready, 1);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].op == 2) do_search(tbl[i].word, tbl[i].mask, tbl[i].exp, tbl[i].stall, 1'b0);
      else do_write(tbl[i].addr, tbl[i].word, tbl[i].op == 1, tbl[i].exp);
    end

    // Simultaneous write and search: write wins, search lands two cycles later and sees the row.
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_addr = 3'd3; bus.wr_word = 8'h77; bus.wr_inv = 1'b0;
    bus.srch_valid = 1'b1; bus.srch_word = 8'h77; bus.srch_mask = 8'h00;
    #1;
    chk("both_wr_ready", bus.wr_ready, 1);
    chk("both_srch_ready", bus.srch_ready, 0);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #1;
    chk("both_we", bus.we_decoded_row_address, 8'h08);
    chk("both_srch_busy", bus.srch_ready, 0);
    m_vld[3] = 1; m_data[3] = 8'h77;
    do_search(8'h77, 8'h00, 8'h08, 0, 1'b0);

    // Reset in REPORT with two hits pending drops them and all valid bits.
    do_write(3'd2, 8'hA5, 1'b0, 8'h04);
    @(negedge clk);
    bus.srch_valid = 1'b1; bus.srch_word = 8'hA5; bus.srch_mask = 8'h00; bus.res_ready = 1'b0;
    @(negedge clk);
    bus.srch_valid = 1'b0;
    @(negedge clk);
    chk("rptrst_valid_before", bus.res_valid, 1);
    chk("rptrst_addr_before", bus.res_addr, 2);
    chk("rptrst_last_before", bus.res_last, 0);
    rst = 1'b1;
    #1;
    chk("rptrst_wr_ready", bus.wr_ready, 0);
    chk("rptrst_srch_ready", bus.srch_ready, 0);
    @(negedge clk);
    chk("rptrst_res_valid", bus.res_valid, 0);
    chk("rptrst_res_last", bus.res_last, 0);
    chk("rptrst_ready_held", bus.wr_ready, 0);
    rst = 1'b0;
    for (int r = 0; r < D; r++) m_vld[r] = 0;
    do_search(8'hA5, 8'h00, 8'h00, 0, 1'b0);

    pool[0] = 8'h5A; pool[1] = 8'h5B; pool[2] = 8'hA5; pool[3] = 8'h4A;
    for (int i = 0; i < 80; i++) begin
      op   = $urandom_range(0, 4);
      addr = 3'($urandom_range(0, D - 1));
      key  = pool[$urandom_range(0, 3)];
      if (op <= 1) begin
        do_write(addr, key, 1'b0, 8'h01 << addr);
      end else if (op == 2) begin
        do_write(addr, key, 1'b1, 8'h00);
      end else begin
        mask = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
        do_search(key, mask, model_hits(key, mask), $urandom_range(0, 1), 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
